// File: rtl/rgb_timing_multi.sv
`default_nettype none
// ============================================================================
// rgb_timing_multi : four-preset video timing generator (HS/VS/DE, X/Y, pulses)
// Optional frame_cnt output enabled by RGB_TIMING_FRAME_CNT_EN.    Rev 1.0
// ============================================================================
module rgb_timing_multi #(
  parameter int COORD_W      = 12,
  parameter int DEFAULT_MODE = 0
) (
  input  logic               rgb_clk,
  input  logic               rgb_rst_n,
  input  logic [1:0]         mode_sel,
  output logic [1:0]         cur_mode,
  output logic               rgb_hs,
  output logic               rgb_vs,
  output logic               rgb_de,
  output logic [COORD_W-1:0] rgb_x,
  output logic [COORD_W-1:0] rgb_y,
  output logic               line_start,
`ifdef RGB_TIMING_FRAME_CNT_EN
  output logic               frame_start,
  output logic [15:0]        frame_cnt
`else
  output logic               frame_start
`endif
);

  localparam logic [1:0] DEF_MODE = 2'(DEFAULT_MODE);

  logic [COORD_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [COORD_W-1:0] h_sync, h_beg, h_end, h_max;
  logic [COORD_W-1:0] v_sync, v_beg, v_end, v_max;
  logic               h_last, v_last, hs_act, vs_act, de;

  logic               hs_q, vs_q, de_q, ls_q, fs_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [1:0]         cur_mode_q;

  // Geometry as counter thresholds: sync end, active begin/end, last count.
  always_comb begin
    h_sync = COORD_W'(96);  h_beg = COORD_W'(144); h_end = COORD_W'(784);  h_max = COORD_W'(799);
    v_sync = COORD_W'(2);   v_beg = COORD_W'(35);  v_end = COORD_W'(515);  v_max = COORD_W'(524);
    case (mode_q)
      2'd1: begin
        h_sync = COORD_W'(128); h_beg = COORD_W'(216); h_end = COORD_W'(1016); h_max = COORD_W'(1055);
        v_sync = COORD_W'(4);   v_beg = COORD_W'(27);  v_end = COORD_W'(627);  v_max = COORD_W'(627);
      end
      2'd2: begin
        h_sync = COORD_W'(136); h_beg = COORD_W'(296); h_end = COORD_W'(1320); h_max = COORD_W'(1343);
        v_sync = COORD_W'(6);   v_beg = COORD_W'(35);  v_end = COORD_W'(803);  v_max = COORD_W'(805);
      end
      2'd3: begin
        h_sync = COORD_W'(40);  h_beg = COORD_W'(260); h_end = COORD_W'(1540); h_max = COORD_W'(1649);
        v_sync = COORD_W'(5);   v_beg = COORD_W'(25);  v_end = COORD_W'(745);  v_max = COORD_W'(749);
      end
      default: ;
    endcase
  end

  assign h_last = (h_cnt_q == h_max);
  assign v_last = (v_cnt_q == v_max);
  assign hs_act = (h_cnt_q < h_sync);
  assign vs_act = (v_cnt_q < v_sync);
  assign de     = (h_cnt_q >= h_beg) && (h_cnt_q < h_end) &&
                  (v_cnt_q >= v_beg) && (v_cnt_q < v_end);

  // mode_sel is only looked at on the very last pixel of a frame.
  always_comb begin
    h_cnt_d = h_last ? '0 : h_cnt_q + COORD_W'(1);
    v_cnt_d = v_cnt_q;
    mode_d  = mode_q;
    if (h_last) begin
      if (v_last) begin
        v_cnt_d = '0;
        mode_d  = mode_sel;
      end else begin
        v_cnt_d = v_cnt_q + COORD_W'(1);
      end
    end
  end

  // Odd modes use positive sync polarity; the idle level is the inverse.
  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      mode_q     <= DEF_MODE;
      cur_mode_q <= DEF_MODE;
      hs_q       <= ~DEF_MODE[0];
      vs_q       <= ~DEF_MODE[0];
      de_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      ls_q       <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      mode_q     <= mode_d;
      cur_mode_q <= mode_q;
      hs_q       <= hs_act ~^ mode_q[0];
      vs_q       <= vs_act ~^ mode_q[0];
      de_q       <= de;
      x_q        <= de ? (h_cnt_q - h_beg) : '0;
      y_q        <= de ? (v_cnt_q - v_beg) : '0;
      ls_q       <= (h_cnt_q == '0);
      fs_q       <= (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

`ifdef RGB_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // At (0,0) cur_mode_q still carries the previous frame's mode.
  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      frame_cnt_q <= '0;
    end else if ((h_cnt_q == '0) && (v_cnt_q == '0)) begin
      frame_cnt_q <= (mode_q != cur_mode_q) ? 16'd0 : frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign cur_mode    = cur_mode_q;
  assign rgb_hs      = hs_q;
  assign rgb_vs      = vs_q;
  assign rgb_de      = de_q;
  assign rgb_x       = x_q;
  assign rgb_y       = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_timing_multi.sv
`default_nettype none
// Bench for rgb_timing_multi: table-driven pixel-position model compared every
// cycle, plus hand-computed line/frame measurements.
module tb_rgb_timing_multi;

  localparam int CW = 12;
  localparam int H_TOT[4]  = '{800, 1056, 1344, 1650};
  localparam int H_SYNC[4] = '{96, 128, 136, 40};
  localparam int H_BP[4]   = '{48, 88, 160, 220};
  localparam int H_ACT[4]  = '{640, 800, 1024, 1280};
  localparam int V_TOT[4]  = '{525, 628, 806, 750};
  localparam int V_SYNC[4] = '{2, 4, 6, 5};
  localparam int V_BP[4]   = '{33, 23, 29, 20};
  localparam int V_ACT[4]  = '{480, 600, 768, 720};
  localparam bit POS[4]    = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic          rgb_clk = 1'b0;
  logic          rgb_rst_n = 1'b0;
  logic [1:0]    mode_sel = 2'd0;
  logic [1:0]    cur_mode;
  logic          rgb_hs, rgb_vs, rgb_de, line_start, frame_start;
  logic [CW-1:0] rgb_x, rgb_y;
`ifdef RGB_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  rgb_timing_multi #(.COORD_W(CW), .DEFAULT_MODE(0)) dut (
    .rgb_clk     (rgb_clk),
    .rgb_rst_n   (rgb_rst_n),
    .mode_sel    (mode_sel),
    .cur_mode    (cur_mode),
    .rgb_hs      (rgb_hs),
    .rgb_vs      (rgb_vs),
    .rgb_de      (rgb_de),
    .rgb_x       (rgb_x),
    .rgb_y       (rgb_y),
    .line_start  (line_start),
`ifdef RGB_TIMING_FRAME_CNT_EN
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
`else
    .frame_start (frame_start)
`endif
  );

  always #5 rgb_clk = ~rgb_clk;

  int checks = 0;
  int failures = 0;

  // Model state: the pixel the DUT counters currently point at.
  int   m_h = 0, m_v = 0, m_mode = 0, px, py;
  logic e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_ls = 1'b0, e_fs = 1'b0;
  int   e_x = 0, e_y = 0;
  logic [1:0] e_cur = 2'd0;
`ifdef RGB_TIMING_FRAME_CNT_EN
  logic [15:0] e_fc = 16'd0;
  bit          m_new = 1'b0;
`endif

  always @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      m_h = 0; m_v = 0; m_mode = 0;
      e_hs = ~POS[0]; e_vs = ~POS[0]; e_de = 1'b0; e_x = 0; e_y = 0;
      e_ls = 1'b0; e_fs = 1'b0; e_cur = 2'd0;
`ifdef RGB_TIMING_FRAME_CNT_EN
      e_fc = 16'd0; m_new = 1'b0;
`endif
    end else begin
      px   = m_h - H_SYNC[m_mode] - H_BP[m_mode];
      py   = m_v - V_SYNC[m_mode] - V_BP[m_mode];
      e_de = (px >= 0) && (px < H_ACT[m_mode]) && (py >= 0) && (py < V_ACT[m_mode]);
      e_x  = e_de ? px : 0;
      e_y  = e_de ? py : 0;
      e_hs = ((m_h < H_SYNC[m_mode]) == POS[m_mode]);
      e_vs = ((m_v < V_SYNC[m_mode]) == POS[m_mode]);
      e_ls = (m_h == 0);
      e_fs = (m_h == 0) && (m_v == 0);
      e_cur = 2'(m_mode);
`ifdef RGB_TIMING_FRAME_CNT_EN
      if (e_fs) e_fc = m_new ? 16'd0 : e_fc + 16'd1;
`endif
      m_h++;
      if (m_h == H_TOT[m_mode]) begin
        m_h = 0;
        m_v++;
        if (m_v == V_TOT[m_mode]) begin
          m_v = 0;
`ifdef RGB_TIMING_FRAME_CNT_EN
          m_new = (int'(mode_sel) != m_mode);
`endif
          m_mode = int'(mode_sel);
        end
      end
    end
  end

  always @(negedge rgb_clk) begin
    bit bad;
    bad = (rgb_hs !== e_hs) || (rgb_vs !== e_vs) || (rgb_de !== e_de) ||
          (rgb_x !== CW'(e_x)) || (rgb_y !== CW'(e_y)) || (line_start !== e_ls) ||
          (frame_start !== e_fs) || (cur_mode !== e_cur);
`ifdef RGB_TIMING_FRAME_CNT_EN
    bad = bad || (frame_cnt !== e_fc);
`endif
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL cycle_cmp t=%0t actual hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b mode=%0d required hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b mode=%0d",
               $time, rgb_hs, rgb_vs, rgb_de, rgb_x, rgb_y, line_start, frame_start, cur_mode,
               e_hs, e_vs, e_de, e_x, e_y, e_ls, e_fs, e_cur);
    end
    if (failures > 200) begin
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // mode_sel noise everywhere except the last line, where the wanted mode is held.
  logic [1:0] target = 2'd0;
  bit         noise_en = 1'b0;
  always @(negedge rgb_clk) begin
    if (m_v == V_TOT[m_mode] - 1) mode_sel = target;
    else if (noise_en)            mode_sel = 2'($urandom_range(0, 3));
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_line();
    int n = 0;
    while (!line_start && n < 4000) begin
      @(negedge rgb_clk);
      n++;
    end
    chk("line_start_seen", int'(line_start), 1);
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge rgb_clk);
      n++;
    end while (!frame_start && n < 20000);
    chk("frame_start_seen", int'(frame_start), 1);
  endtask

  int ml_len, ml_hs, ml_vs, ml_de, ml_off, ml_fx, ml_fy, ml_lx, ml_ly;
  task automatic measure_line();
    wait_line();
    ml_len = 0; ml_hs = 0; ml_vs = 0; ml_de = 0; ml_off = -1;
    ml_fx = -1; ml_fy = -1; ml_lx = -1; ml_ly = -1;
    do begin
      if (rgb_hs) ml_hs++;
      if (rgb_vs) ml_vs++;
      if (rgb_de) begin
        if (ml_off < 0) begin
          ml_off = ml_len; ml_fx = int'(rgb_x); ml_fy = int'(rgb_y);
        end
        ml_lx = int'(rgb_x); ml_ly = int'(rgb_y);
        ml_de++;
      end
      ml_len++;
      @(negedge rgb_clk);
    end while (!line_start && ml_len < 4000);
  endtask

  // Skip ahead vertically: moves both DUT and model to row v at pixel h=1.
  logic [CW-1:0] force_v;
  task automatic jump_v(input int v);
    wait_line();
    #1;
    force_v = CW'(v);
    force dut.v_cnt_q = force_v;
    m_v = v;
    @(negedge rgb_clk);
    #1;
    release dut.v_cnt_q;
  endtask

  task automatic switch_to(input logic [1:0] t);
    target = t;
    jump_v(V_TOT[m_mode] - 2);
    wait_frame();
    chk("switch_cur_mode", int'(cur_mode), int'(t));
  endtask

  initial begin
    int vs_sum;
    repeat (3) @(negedge rgb_clk);
    chk("rst_hs", int'(rgb_hs), 1);
    chk("rst_vs", int'(rgb_vs), 1);
    chk("rst_de", int'(rgb_de), 0);
    chk("rst_x", int'(rgb_x), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_ls", int'(line_start), 0);
    chk("rst_mode", int'(cur_mode), 0);
    #2 rgb_rst_n = 1'b1;
    @(negedge rgb_clk);
    chk("rel_fs", int'(frame_start), 1);
    chk("rel_ls", int'(line_start), 1);
    chk("rel_hs", int'(rgb_hs), 0);
    chk("rel_vs", int'(rgb_vs), 0);
    noise_en = 1'b1;

    vs_sum = 0;
    for (int i = 0; i < 3; i++) begin
      measure_line();
      vs_sum += ml_vs;
      if (i == 0) begin
        chk("m0_line_len", ml_len, 800);
        chk("m0_hs_high", ml_hs, 704);
        chk("m0_de_blank", ml_de, 0);
      end
    end
    chk("m0_vs_high_3lines", vs_sum, 800);

    jump_v(34);
    measure_line();
    chk("m0_first_de_count", ml_de, 640);
    chk("m0_first_de_offset", ml_off, 144);
    chk("m0_first_x", ml_fx, 0);
    chk("m0_first_y", ml_fy, 0);
    jump_v(513);
    measure_line();
    chk("m0_last_de_count", ml_de, 640);
    chk("m0_last_x", ml_lx, 639);
    chk("m0_last_y", ml_ly, 479);

    target = 2'd3;
    wait_frame();
    chk("sw3_cur_mode", int'(cur_mode), 3);
    chk("sw3_hs", int'(rgb_hs), 1);
    chk("sw3_vs", int'(rgb_vs), 1);
    vs_sum = 0;
    for (int i = 0; i < 6; i++) begin
      measure_line();
      vs_sum += ml_vs;
      chk("m3_line_len", ml_len, 1650);
      if (i == 0) chk("m3_hs_high", ml_hs, 40);
    end
    chk("m3_vs_high_6lines", vs_sum, 8250);

    switch_to(2'd1);
    measure_line();
    chk("m1_line_len", ml_len, 1056);
    chk("m1_hs_high", ml_hs, 128);
    chk("m1_vs_high", ml_vs, 1056);

    switch_to(2'd2);
`ifdef RGB_TIMING_FRAME_CNT_EN
    chk("fc_cleared_on_switch", int'(frame_cnt), 0);
`endif
    measure_line();
    chk("m2_line_len", ml_len, 1344);
    chk("m2_hs_high", ml_hs, 1208);
    chk("m2_vs_high", ml_vs, 0);

    target = 2'd2;
    jump_v(V_TOT[m_mode] - 2);
`ifdef RGB_TIMING_FRAME_CNT_EN
    force dut.frame_cnt_q = 16'hFFFF;
    e_fc = 16'hFFFF;
    @(negedge rgb_clk);
    #1;
    release dut.frame_cnt_q;
`endif
    wait_frame();
    chk("noop_cur_mode", int'(cur_mode), 2);
`ifdef RGB_TIMING_FRAME_CNT_EN
    chk("fc_wrap", int'(frame_cnt), 0);
`endif
    measure_line();
    chk("noop_line_len", ml_len, 1344);

    for (int i = 0; i < 2; i++) begin
      switch_to(2'($urandom_range(0, 3)));
      measure_line();
    end

    switch_to(2'd2);
    repeat (500) @(negedge rgb_clk);
    #3 rgb_rst_n = 1'b0;
    #1;
    chk("arst_hs", int'(rgb_hs), 1);
    chk("arst_vs", int'(rgb_vs), 1);
    chk("arst_de", int'(rgb_de), 0);
    chk("arst_x", int'(rgb_x), 0);
    chk("arst_y", int'(rgb_y), 0);
    chk("arst_ls", int'(line_start), 0);
    chk("arst_fs", int'(frame_start), 0);
    chk("arst_mode", int'(cur_mode), 0);
    repeat (2) @(negedge rgb_clk);
    #2 rgb_rst_n = 1'b1;
    @(negedge rgb_clk);
    chk("arel_fs", int'(frame_start), 1);
    chk("arel_ls", int'(line_start), 1);
    chk("arel_hs", int'(rgb_hs), 0);
    chk("arel_mode", int'(cur_mode), 0);
    measure_line();
    chk("arel_line_len", ml_len, 800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
